// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 responder for the accelerometer write/read/FIFO command set
//
// Oversamples CS/SCLK/MOSI in the CLK domain, decodes 0x0A (write), 0x0B (register read)
// and 0x0D (FIFO read), serves a 64-byte register map and reports accepted writes.
//
// Ports:
//   CLK, RST           system clock, synchronous active-high reset
//   CS, SCLK, MOSI     SPI pins, asynchronous to CLK (CS active-low, SCLK idle low)
//   MISO               serial read data, MSB first, 0 when not shifting read data
//   X/Y/Z_DATA         new sample values, latched into 0x08/0x09/0x0A on SAMPLE_VALID
//   FIFO_DATA/EMPTY    head byte and empty flag of the external FIFO
//   FIFO_RD            one-cycle pop pulse per FIFO byte load
//   WR_STROBE          one-cycle pulse per accepted register write, with WR_ADDR/WR_DATA
module spi_responder (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [7:0] X_DATA,
  input  logic [7:0] Y_DATA,
  input  logic [7:0] Z_DATA,
  input  logic       SAMPLE_VALID,
  input  logic [7:0] FIFO_DATA,
  input  logic       FIFO_EMPTY,
  output logic       FIFO_RD,
  output logic       WR_STROBE,
  output logic [5:0] WR_ADDR,
  output logic [7:0] WR_DATA
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INSTR  = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_FIFO   = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_FIFO  = 8'h0D;

  localparam logic [5:0] RAM_BASE  = 6'h1F;

  logic        cs_s1, cs_s2;
  logic        sclk_s1, sclk_s2, sclk_s3;
  logic        mosi_s1, mosi_s2;
  logic        sclk_rise, sclk_fall;

  logic [2:0]  state;
  logic        cs_armed;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  byte_next;
  logic        byte_done;
  logic        is_write;
  logic        load_pend;
  logic [5:0]  ptr;
  logic [5:0]  ram_idx;
  logic        ram_we;
  logic [7:0]  shift_out;
  logic [7:0]  map_rd;
  logic [7:0]  x_reg, y_reg, z_reg;
  logic [32:0][7:0] ram;

  // Two-flop synchronisers; the third SCLK flop provides edge detection.
  // CS flops reset to the asserted level so that a CS held low across reset
  // is treated as a frame already in progress rather than a fresh falling edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= CS;
      cs_s2   <= cs_s1;
      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign byte_next = {shift_in, mosi_s2};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign ram_idx   = ptr - RAM_BASE;
  assign ram_we    = !cs_s2 && (state == ST_WDATA) && byte_done && (ptr >= RAM_BASE);

  assign MISO = ((state == ST_RDATA) || (state == ST_FIFO)) ? shift_out[7] : 1'b0;

  // Sample registers update on the edge that sees SAMPLE_VALID, so a byte load
  // in that same cycle still reads the previous value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_reg <= 8'h00;
      y_reg <= 8'h00;
      z_reg <= 8'h00;
    end else if (SAMPLE_VALID) begin
      x_reg <= X_DATA;
      y_reg <= Y_DATA;
      z_reg <= Z_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ram <= '0;
    end else if (ram_we) begin
      ram[ram_idx] <= byte_next;
    end
  end

  always_comb begin
    map_rd = 8'h00;
    case (ptr)
      6'h00:   map_rd = 8'hAD;
      6'h01:   map_rd = 8'h1D;
      6'h02:   map_rd = 8'hF2;
      6'h03:   map_rd = 8'h01;
      6'h08:   map_rd = x_reg;
      6'h09:   map_rd = y_reg;
      6'h0A:   map_rd = z_reg;
      default: if (ptr >= RAM_BASE) map_rd = ram[ram_idx];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      cs_armed  <= 1'b0;
      bit_cnt   <= 3'd0;
      shift_in  <= 7'd0;
      is_write  <= 1'b0;
      load_pend <= 1'b0;
      ptr       <= 6'd0;
      shift_out <= 8'h00;
      FIFO_RD   <= 1'b0;
      WR_STROBE <= 1'b0;
      WR_ADDR   <= 6'd0;
      WR_DATA   <= 8'h00;
    end else begin
      FIFO_RD   <= 1'b0;
      WR_STROBE <= 1'b0;
      if (cs_s2) begin
        // Deselect aborts everything; a partial byte is simply dropped.
        state     <= ST_IDLE;
        cs_armed  <= 1'b1;
        bit_cnt   <= 3'd0;
        shift_in  <= 7'd0;
        load_pend <= 1'b0;
        shift_out <= 8'h00;
      end else begin
        if (sclk_rise) begin
          shift_in <= byte_next[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        case (state)
          ST_IDLE: begin
            // Only a CS low that followed a seen-high CS starts a frame.
            state <= cs_armed ? ST_INSTR : ST_IGNORE;
          end
          ST_INSTR: begin
            if (byte_done) begin
              case (byte_next)
                CMD_WRITE: begin
                  is_write <= 1'b1;
                  state    <= ST_ADDR;
                end
                CMD_READ: begin
                  is_write <= 1'b0;
                  state    <= ST_ADDR;
                end
                CMD_FIFO: begin
                  load_pend <= 1'b1;
                  state     <= ST_FIFO;
                end
                default: state <= ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            if (byte_done) begin
              ptr <= byte_next[5:0];
              if (is_write) begin
                state <= ST_WDATA;
              end else begin
                load_pend <= 1'b1;
                state     <= ST_RDATA;
              end
            end
          end
          ST_WDATA: begin
            if (byte_done) begin
              if (ptr >= RAM_BASE) begin
                WR_STROBE <= 1'b1;
                WR_ADDR   <= ptr;
                WR_DATA   <= byte_next;
              end
              ptr <= ptr + 6'd1;
            end
          end
          ST_RDATA, ST_FIFO: begin
            // A completed byte arms a load for the following SCLK fall; every
            // other fall shifts the next bit onto MISO.
            if (byte_done) begin
              load_pend <= 1'b1;
            end
            if (sclk_fall) begin
              if (load_pend) begin
                load_pend <= 1'b0;
                if (state == ST_FIFO) begin
                  shift_out <= FIFO_EMPTY ? 8'h00 : FIFO_DATA;
                  FIFO_RD   <= !FIFO_EMPTY;
                end else begin
                  shift_out <= map_rd;
                  ptr       <= ptr + 6'd1;
                end
              end else begin
                shift_out <= {shift_out[6:0], 1'b0};
              end
            end
          end
          default: begin
            // ST_IGNORE holds until CS is seen high.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - directed vector bench for spi_responder
module tb_spi_responder;

  localparam int SCLK_MIN_HALF = 4;
  localparam int HALF = SCLK_MIN_HALF + 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CS;
  logic       SCLK;
  logic       MOSI;
  logic       MISO;
  logic [7:0] X_DATA;
  logic [7:0] Y_DATA;
  logic [7:0] Z_DATA;
  logic       SAMPLE_VALID;
  logic [7:0] FIFO_DATA;
  logic       FIFO_EMPTY;
  logic       FIFO_RD;
  logic       WR_STROBE;
  logic [5:0] WR_ADDR;
  logic [7:0] WR_DATA;

  spi_responder dut (
    .CLK(CLK), .RST(RST), .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .X_DATA(X_DATA), .Y_DATA(Y_DATA), .Z_DATA(Z_DATA), .SAMPLE_VALID(SAMPLE_VALID),
    .FIFO_DATA(FIFO_DATA), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RD(FIFO_RD),
    .WR_STROBE(WR_STROBE), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  int         wr_cnt = 0;
  int         fifo_rd_cnt = 0;
  int         miso_hi_cnt = 0;
  logic [5:0] last_waddr = '0;
  logic [7:0] last_wdata = '0;

  // External FIFO model: pops on each cycle FIFO_RD is high.
  logic [7:0] fifo_mem [4];
  int         fifo_len = 0;
  int         fifo_head = 0;

  assign FIFO_DATA  = (fifo_head < 4) ? fifo_mem[fifo_head[1:0]] : 8'hEE;
  assign FIFO_EMPTY = (fifo_head >= fifo_len);

  always @(posedge CLK) begin
    if (FIFO_RD) fifo_head <= fifo_head + 1;
  end

  always @(negedge CLK) begin
    if (WR_STROBE) begin
      wr_cnt++;
      last_waddr = WR_ADDR;
      last_wdata = WR_DATA;
    end
    if (FIFO_RD) fifo_rd_cnt++;
    if (MISO) miso_hi_cnt++;
  end

  typedef struct {
    int          n;
    logic [39:0] tx;
    logic [39:0] rx;
    int          nstb;
    logic [5:0]  waddr;
    logic [7:0]  wdata;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [39:0] tx, input logic [39:0] rx,
                              input int nstb, input logic [5:0] wa, input logic [7:0] wd);
    vec_t v;
    v.n = n;
    v.tx = tx;
    v.rx = rx;
    v.nstb = nstb;
    v.waddr = wa;
    v.wdata = wd;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = tx[i];
      repeat (HALF) @(negedge CLK);
      rx[i] = MISO;
      SCLK = 1'b1;
      repeat (HALF) @(negedge CLK);
      SCLK = 1'b0;
    end
  endtask

  task automatic cs_low();
    CS = 1'b0;
    repeat (HALF) @(negedge CLK);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge CLK);
    CS = 1'b1;
    MOSI = 1'b0;
    repeat (2 * HALF) @(negedge CLK);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [7:0] rx;
    int wr0;
    wr0 = wr_cnt;
    cs_low();
    for (int b = 0; b < v.n; b++) begin
      spi_bits(v.tx[39-8*b -: 8], 8, rx);
      check($sformatf("%s byte%0d", tag, b), int'(rx), int'(v.rx[39-8*b -: 8]));
    end
    cs_high();
    check($sformatf("%s strobes", tag), wr_cnt - wr0, v.nstb);
    if (v.nstb > 0) begin
      check($sformatf("%s wr_addr", tag), int'(last_waddr), int'(v.waddr));
      check($sformatf("%s wr_data", tag), int'(last_wdata), int'(v.wdata));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " MISO"}, int'(MISO), 0);
    check({tag, " FIFO_RD"}, int'(FIFO_RD), 0);
    check({tag, " WR_STROBE"}, int'(WR_STROBE), 0);
    check({tag, " WR_ADDR"}, int'(WR_ADDR), 0);
    check({tag, " WR_DATA"}, int'(WR_DATA), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    logic [7:0] rx;
    int wr0;
    int ff0;

    fifo_mem[0] = 8'hA1;
    fifo_mem[1] = 8'hB2;
    fifo_mem[2] = 8'hEE;
    fifo_mem[3] = 8'hEE;

    RST = 1'b1;
    CS = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    X_DATA = 8'h00;
    Y_DATA = 8'h00;
    Z_DATA = 8'h00;
    SAMPLE_VALID = 1'b0;

    //               n  tx (byte0 first)  expected MISO bytes   strobes addr   data
    vecs.push_back(mk(4, 40'h0B00000000, 40'h0000AD1D00, 0, 6'h00, 8'h00)); // device ID
    vecs.push_back(mk(3, 40'h0A2D020000, 40'h0000000000, 1, 6'h2D, 8'h02)); // write 0x2D
    vecs.push_back(mk(3, 40'h0B2D000000, 40'h0000020000, 0, 6'h00, 8'h00)); // read back
    vecs.push_back(mk(3, 40'h0A08550000, 40'h0000000000, 0, 6'h00, 8'h00)); // read-only write
    vecs.push_back(mk(3, 40'h0B08000000, 40'h0000000000, 0, 6'h00, 8'h00)); // 0x08 unchanged
    vecs.push_back(mk(4, 40'h0B02000000, 40'h0000F20100, 0, 6'h00, 8'h00)); // 0x02, 0x03
    vecs.push_back(mk(4, 40'h0A1E778800, 40'h0000000000, 1, 6'h1F, 8'h88)); // 0x1E ro, 0x1F rw
    vecs.push_back(mk(4, 40'h0B1E000000, 40'h0000008800, 0, 6'h00, 8'h00)); // read 0x1E/0x1F
    vecs.push_back(mk(4, 40'h0A3FC35A00, 40'h0000000000, 1, 6'h3F, 8'hC3)); // 0x3F then wrap ro
    vecs.push_back(mk(5, 40'h0B3F000000, 40'h0000C3AD1D, 0, 6'h00, 8'h00)); // wrap read
    vecs.push_back(mk(3, 40'h0BC1000000, 40'h00001D0000, 0, 6'h00, 8'h00)); // addr[7:6] ignored
    vecs.push_back(mk(3, 40'h0AED9E0000, 40'h0000000000, 1, 6'h2D, 8'h9E)); // write via 0xED
    vecs.push_back(mk(3, 40'h0B2D000000, 40'h00009E0000, 0, 6'h00, 8'h00)); // read 0x2D
    vecs.push_back(mk(3, 40'h0B05000000, 40'h0000000000, 0, 6'h00, 8'h00)); // unmapped ro

    repeat (4) @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;
    repeat (10) @(negedge CLK);

    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Sample collision: SAMPLE_VALID lands on the load edge 3 CLK after the pin fall.
    X_DATA = 8'h12;
    cs_low();
    spi_bits(8'h0B, 8, rx);
    check("collide instr", int'(rx), 0);
    spi_bits(8'h08, 8, rx);
    check("collide addr", int'(rx), 0);
    @(negedge CLK);
    @(negedge CLK);
    SAMPLE_VALID = 1'b1;
    @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    spi_bits(8'h00, 8, rx);
    check("collide old value", int'(rx), 8'h00);
    cs_high();
    run_frame(mk(3, 40'h0B08000000, 40'h0000120000, 0, 6'h00, 8'h00), "collide reread");

    // FIFO read: two entries then empty.
    fifo_len = 2;
    ff0 = fifo_rd_cnt;
    run_frame(mk(4, 40'h0D00000000, 40'h00A1B20000, 0, 6'h00, 8'h00), "fifo");
    check("fifo rd cycles", fifo_rd_cnt - ff0, 2);

    // CS rise after 5 bits of a write data byte.
    wr0 = wr_cnt;
    cs_low();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h30, 8, rx);
    spi_bits(8'hA5, 5, rx);
    cs_high();
    check("abort strobes", wr_cnt - wr0, 0);
    run_frame(mk(3, 40'h0B30000000, 40'h0000000000, 0, 6'h00, 8'h00), "abort readback");

    // Unknown instruction keeps MISO low for the whole frame.
    miso_hi_cnt = 0;
    run_frame(mk(3, 40'h33FFFF0000, 40'h0000000000, 0, 6'h00, 8'h00), "ignore");
    check("ignore miso high cycles", miso_hi_cnt, 0);

    // Reset mid-frame with CS held low.
    cs_low();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 3, rx);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_outputs("midreset");
    RST = 1'b0;
    repeat (HALF) @(negedge CLK);
    wr0 = wr_cnt;
    miso_hi_cnt = 0;
    spi_bits(8'h0A, 8, rx);
    check("post-reset instr", int'(rx), 0);
    spi_bits(8'h31, 8, rx);
    spi_bits(8'h44, 8, rx);
    check("post-reset data", int'(rx), 0);
    cs_high();
    check("post-reset strobes", wr_cnt - wr0, 0);
    check("post-reset miso high cycles", miso_hi_cnt, 0);
    run_frame(mk(3, 40'h0B2D000000, 40'h0000000000, 0, 6'h00, 8'h00), "ram cleared");
    run_frame(mk(3, 40'h0B08000000, 40'h0000000000, 0, 6'h00, 8'h00), "sample cleared");
    run_frame(mk(3, 40'h0B00000000, 40'h0000AD0000, 0, 6'h00, 8'h00), "decode after cs cycle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
